button_debounce3: RTL and testbench

BUTTON_DEBOUNCE3 -- requirements
Module: button_debounce3

---
 rtl/button_debounce3.sv | 125 ++++++++++++
 tb/tb_button_debounce3.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/button_debounce3.sv
// Three-channel push-button debouncer: 2-flop synchronizer, per-channel
// counter and FSM, registered levels plus one-cycle rise/fall pulses.
module button_debounce3 #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [2:0] btn,
    output logic       x0,
    output logic       x1,
    output logic       x2,
    output logic [2:0] rise,
    output logic [2:0] fall
);

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO  = '0;

    logic [2:0]       s1_q, s1_d;
    logic [2:0]       s2_q, s2_d;
    logic [2:0]       x_q, x_d;
    logic [2:0]       rise_q, rise_d;
    logic [2:0]       fall_q, fall_d;
    state_t           state_q [3];
    state_t           state_d [3];
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q   <= '0;
            s2_q   <= '0;
            x_q    <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= STABLE_LO;
                cnt_q[i]   <= ZERO;
            end
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            x_q    <= x_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // A sample matching the current output aborts the wait with no pulse.
    always_comb begin
        s1_d   = btn;
        s2_d   = s1_q;
        x_d    = x_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                STABLE_LO: begin
                    if (s2_q[i]) begin
                        state_d[i] = WAIT_HI;
                        cnt_d[i]   = ONE;
                    end
                end
                WAIT_HI: begin
                    if (!s2_q[i]) begin
                        state_d[i] = STABLE_LO;
                        cnt_d[i]   = ZERO;
                    end else if (cnt_q[i] == LIMIT) begin
                        state_d[i] = STABLE_HI;
                        cnt_d[i]   = ZERO;
                        x_d[i]     = 1'b1;
                        rise_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + ONE;
                    end
                end
                STABLE_HI: begin
                    if (!s2_q[i]) begin
                        state_d[i] = WAIT_LO;
                        cnt_d[i]   = ONE;
                    end
                end
                WAIT_LO: begin
                    if (s2_q[i]) begin
                        state_d[i] = STABLE_HI;
                        cnt_d[i]   = ZERO;
                    end else if (cnt_q[i] == LIMIT) begin
                        state_d[i] = STABLE_LO;
                        cnt_d[i]   = ZERO;
                        x_d[i]     = 1'b0;
                        fall_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + ONE;
                    end
                end
                default: begin
                    state_d[i] = STABLE_LO;
                    cnt_d[i]   = ZERO;
                end
            endcase
        end
    end

    assign x0   = x_q[0];
    assign x1   = x_q[1];
    assign x2   = x_q[2];
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_button_debounce3.sv
// Directed vector bench for button_debounce3 with DEBOUNCE_CYCLES=4.
module tb_button_debounce3;

    logic       clk;
    logic       rstn;
    logic [2:0] btn;
    logic       x0, x1, x2;
    logic [2:0] rise, fall;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [2:0] btn;
        logic [2:0] x;
        logic [2:0] r;
        logic [2:0] f;
    } vec_t;

    vec_t tbl[$];

    button_debounce3 #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(24)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .btn (btn),
        .x0  (x0),
        .x1  (x1),
        .x2  (x2),
        .rise(rise),
        .fall(fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic [2:0] b, input logic [2:0] x,
                                input logic [2:0] r, input logic [2:0] f,
                                input int n);
        vec_t v;
        v.btn = b;
        v.x   = x;
        v.r   = r;
        v.f   = f;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [8:0] exp);
        logic [8:0] act;
        act = {x2, x1, x0, rise, fall};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got x/rise/fall=%b, want %b", nm, act, exp);
        end
        n_tests++;
        if ((rise & fall) !== 3'b000) begin
            n_fail++;
            $display("FAIL %s overlap: rise=%b fall=%b", nm, rise, fall);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn    = 1'b0;
        btn     = 3'b000;

        // S1: idle
        add(3'b000, 3'b000, 3'b000, 3'b000, 20);
        // S2: btn0 held
        add(3'b001, 3'b000, 3'b000, 3'b000, 6);
        add(3'b001, 3'b001, 3'b001, 3'b000, 1);
        add(3'b001, 3'b001, 3'b000, 3'b000, 3);
        // S3: short glitch on btn1
        add(3'b011, 3'b001, 3'b000, 3'b000, 3);
        add(3'b001, 3'b001, 3'b000, 3'b000, 8);
        // release btn0
        add(3'b000, 3'b001, 3'b000, 3'b000, 6);
        add(3'b000, 3'b000, 3'b000, 3'b001, 1);
        add(3'b000, 3'b000, 3'b000, 3'b000, 3);
        // S4: all channels together
        add(3'b111, 3'b000, 3'b000, 3'b000, 6);
        add(3'b111, 3'b111, 3'b111, 3'b000, 1);
        add(3'b111, 3'b111, 3'b000, 3'b000, 3);
        add(3'b000, 3'b111, 3'b000, 3'b000, 6);
        add(3'b000, 3'b000, 3'b000, 3'b111, 1);
        add(3'b000, 3'b000, 3'b000, 3'b000, 3);
        // S5: bouncing btn2 then held
        add(3'b100, 3'b000, 3'b000, 3'b000, 1);
        add(3'b000, 3'b000, 3'b000, 3'b000, 1);
        add(3'b100, 3'b000, 3'b000, 3'b000, 1);
        add(3'b000, 3'b000, 3'b000, 3'b000, 1);
        add(3'b100, 3'b000, 3'b000, 3'b000, 6);
        add(3'b100, 3'b100, 3'b100, 3'b000, 1);
        add(3'b100, 3'b100, 3'b000, 3'b000, 3);

        tick();
        tick();
        check("reset", 9'b0);
        rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            btn = tbl[i].btn;
            tick();
            check($sformatf("vec%0d", i),
                  {tbl[i].x, tbl[i].r, tbl[i].f});
        end

        // S6: reset mid-count, btn0 still high on release
        rstn = 1'b0;
        #1;
        check("async_rst", 9'b0);
        tick();
        rstn = 1'b1;
        btn  = 3'b001;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("s6_pre%0d", k), 9'b0);
        end
        rstn = 1'b0;
        #1;
        check("s6_rst_mid", 9'b0);
        tick();
        check("s6_rst_hold", 9'b0);
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k < 6)
                check($sformatf("s6_post%0d", k), 9'b0);
            else if (k == 6)
                check("s6_rise", {3'b001, 3'b001, 3'b000});
            else
                check("s6_hold", {3'b001, 3'b000, 3'b000});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
